// File: rtl/disp_vramrd.sv
// Display VRAM reader: fetches one frame from memory in 16-beat AXI read bursts
// on each vertical-sync falling edge and streams the pixel words into the display FIFO.
module disp_vramrd #(
    parameter int unsigned FRAME_BURSTS = 19200
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        DSP_VSYNC_X,
    input  logic        DISPON,
    input  logic [28:0] DISPADDR,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic        RVALID,
    input  logic        RLAST,
    output logic        RREADY,
    output logic [31:0] BUF_WDATA,
    output logic        BUF_WR,
    input  logic        BUF_AFULL
);

    localparam int unsigned CNT_W   = 15;
    localparam int unsigned BASE_W  = 29;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BEAT_LG = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITBUF,
        S_ADDR,
        S_DATA
    } state_t;

    state_t              state_q, state_d;
    logic                vsync_q, vsync_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;

    logic frame_start;
    logic frame_load;
    logic burst_done;
    logic last_burst;

    assign frame_start = vsync_q & ~DSP_VSYNC_X;
    assign frame_load  = (state_q == S_IDLE) & frame_start & DISPON;
    assign burst_done  = (state_q == S_DATA) & RVALID & RLAST;
    assign last_burst  = (count_q == CNT_W'(FRAME_BURSTS - 1));

    // State and datapath registers
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q  <= S_IDLE;
            vsync_q  <= 1'b1;
            base_q   <= '0;
            count_q  <= '0;
            araddr_q <= '0;
        end else begin
            state_q  <= state_d;
            vsync_q  <= vsync_d;
            base_q   <= base_d;
            count_q  <= count_d;
            araddr_q <= araddr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (frame_load) state_d = S_WAITBUF;
            S_WAITBUF: if (!BUF_AFULL) state_d = S_ADDR;
            S_ADDR:    if (ARREADY)    state_d = S_DATA;
            S_DATA: begin
                if (burst_done) begin
                    state_d = (last_burst || !DISPON) ? S_IDLE : S_WAITBUF;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Burst address only moves at frame load or burst completion, so it is stable in S_ADDR
    always_comb begin
        vsync_d  = DSP_VSYNC_X;
        base_d   = base_q;
        count_d  = count_q;
        if (frame_load) begin
            base_d  = DISPADDR;
            count_d = '0;
        end else if (burst_done) begin
            count_d = count_q + CNT_W'(1);
        end
        araddr_d = {3'b000, base_d} + {(ADDR_W - CNT_W - BEAT_LG)'(0), count_d, BEAT_LG'(0)};
    end

    // Output decode
    always_comb begin
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        case (state_q)
            S_ADDR:  ARVALID = 1'b1;
            S_DATA:  RREADY  = 1'b1;
            default: ;
        endcase
    end

    assign ARADDR    = araddr_q;
    assign ARLEN     = 8'd15;
    assign BUF_WR    = RVALID & RREADY;
    assign BUF_WDATA = RDATA;

endmodule

// File: tb/tb_disp_vramrd.sv
// Bench for disp_vramrd: AXI read slave, transaction-level frame model and per-cycle checker.
module tb_disp_vramrd;

    localparam int unsigned NB = 24;

    logic        clk = 1'b0;
    logic        arst, vsync_x, dispon, arready, rvalid, rlast, buf_afull;
    logic [28:0] dispaddr;
    logic [31:0] araddr, rdata, buf_wdata;
    logic [7:0]  arlen;
    logic        arvalid, rready, buf_wr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model of the frame in progress
    logic        m_active = 1'b0, m_outs = 1'b0;
    logic [31:0] m_base = '0;
    int          m_idx = 0, hs_cnt = 0, wr_cnt = 0, cur_beats = 0, gap = 0;
    logic [31:0] addr_q[$];
    logic        vs_prev = 1'b1, arv_prev = 1'b0, arr_prev = 1'b0, afull_prev = 1'b0;
    logic [31:0] ara_prev = '0;
    logic        rst_chk = 1'b0, fs, was_idle;

    // slave state
    logic s_pend = 1'b0;
    int   s_beat = 0;

    always #5 clk = ~clk;

    disp_vramrd #(.FRAME_BURSTS(NB)) dut (
        .ACLK(clk), .ARST(arst), .DSP_VSYNC_X(vsync_x), .DISPON(dispon), .DISPADDR(dispaddr),
        .ARADDR(araddr), .ARLEN(arlen), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RVALID(rvalid), .RLAST(rlast), .RREADY(rready),
        .BUF_WDATA(buf_wdata), .BUF_WR(buf_wr), .BUF_AFULL(buf_afull)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    // Checker and model update, evaluated half a cycle before each rising edge
    always @(negedge clk) begin
        cyc++;
        if (rst_chk) begin
            chk("rst_arvalid", arvalid, 0);
            chk("rst_rready", rready, 0);
            chk("rst_buf_wr", buf_wr, 0);
            chk("rst_araddr", araddr, 0);
        end
        rst_chk = arst;
        if (arst) begin
            m_active = 0; m_outs = 0; cur_beats = 0; gap = 0;
            vs_prev = 1; arv_prev = 0; arr_prev = 0; afull_prev = 0;
        end else begin
            chk("rready", rready, m_outs);
            chk("buf_wr", buf_wr, rvalid && m_outs);
            if (buf_wr) chk("buf_wdata", buf_wdata, rdata);
            if (!m_active || m_outs) chk("arvalid_off", arvalid, 0);
            if (arv_prev && !arr_prev) begin
                chk("arvalid_hold", arvalid, 1);
                chk("araddr_hold", araddr, ara_prev);
            end
            if (arvalid && !arv_prev) chk("ar_rise_afull", afull_prev, 0);
            if (arvalid) begin
                chk("araddr", araddr, m_base + 32'(m_idx) * 32'd64);
                chk("arlen", arlen, 15);
            end
            if (m_active && !m_outs && !arvalid && !buf_afull) gap++; else gap = 0;
            if (m_active && !m_outs && !arvalid) chk("ar_issue_gap", 32'(gap < 2), 1);
            if (buf_wr) begin wr_cnt++; cur_beats++; end

            was_idle = !m_active && !m_outs;
            fs = vs_prev && !vsync_x;
            if (arvalid && arready) begin
                m_outs = 1; hs_cnt++; addr_q.push_back(araddr);
            end else if (m_outs && rvalid && rlast) begin
                chk("beats_per_burst", cur_beats, 16);
                cur_beats = 0; m_outs = 0; m_idx++;
                if (m_idx == int'(NB) || !dispon) m_active = 0;
            end
            if (fs && was_idle && dispon) begin
                m_active = 1; m_base = {3'b000, dispaddr}; m_idx = 0;
            end
            vs_prev = vsync_x; arv_prev = arvalid; arr_prev = arready;
            ara_prev = araddr; afull_prev = buf_afull;
        end
    end

    // AXI read-data slave: 16 beats per accepted address, periodic RVALID gaps
    initial begin
        rvalid = 0; rlast = 0; rdata = '0;
        forever begin
            @(negedge clk);
            if (arst) begin
                s_pend = 0; s_beat = 0;
            end else begin
                if (rvalid && rready) begin
                    if (rlast) begin s_pend = 0; s_beat = 0; end
                    else s_beat++;
                end
                if (arvalid && arready) s_pend = 1;
            end
            @(posedge clk);
            #1;
            rvalid = s_pend && (cyc % 7 != 3);
            rlast  = s_pend && (s_beat == 15);
            rdata  = $urandom;
        end
    end

    task automatic wait_hs(input int n, input string name);
        for (int i = 0; i < 2000 && hs_cnt < n; i++) cyc1();
        chk(name, hs_cnt, n);
    endtask

    task automatic wait_beats(input int b, input string name);
        for (int i = 0; i < 200 && !(m_outs && cur_beats == b); i++) cyc1();
        chk(name, cur_beats, b);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && m_active; i++) cyc1();
        chk(name, m_active, 0);
    endtask

    task automatic wait_outs_end(input string name);
        for (int i = 0; i < 200 && m_outs; i++) cyc1();
        chk(name, m_outs, 0);
    endtask

    task automatic start_frame(input logic [28:0] base);
        hs_cnt = 0; wr_cnt = 0; addr_q.delete();
        dispaddr = base; dispon = 1; vsync_x = 0;
        cyc1(); cyc1();
        vsync_x = 1;
        cyc1();
    endtask

    initial begin
        arst = 1; vsync_x = 1; dispon = 0; dispaddr = '0; arready = 1; buf_afull = 0;
        repeat (3) cyc1();
        arst = 0;
        cyc1();
        chk("post_rst_arvalid", arvalid, 0);
        chk("post_rst_araddr", araddr, 32'h0);

        // basic bursts, backpressure, buffer full, ignored vsync, full frame
        start_frame(29'h0100_0000);
        wait_hs(2, "basic_two_hs");
        chk("first_araddr", addr_q[0], 32'h0100_0000);
        chk("second_araddr", addr_q[1], 32'h0100_0040);

        wait_hs(3, "bp_setup");
        arready = 0;
        for (int i = 0; i < 200 && !arvalid; i++) cyc1();
        chk("bp_arvalid_seen", arvalid, 1);
        repeat (10) begin
            chk("bp_arvalid", arvalid, 1);
            chk("bp_araddr", araddr, 32'h0100_00C0);
            cyc1();
        end
        chk("bp_no_hs", hs_cnt, 3);
        arready = 1;
        wait_hs(4, "bp_single_hs");
        chk("bp_addr", addr_q[3], 32'h0100_00C0);

        wait_hs(5, "afull_setup");
        buf_afull = 1;
        wait_outs_end("afull_burst_end");
        repeat (50) begin
            chk("afull_arvalid", arvalid, 0);
            cyc1();
        end
        buf_afull = 0;
        wait_hs(6, "afull_resume");
        chk("afull_next_addr", addr_q[5], 32'h0100_0140);

        wait_hs(8, "vs2_setup");
        vsync_x = 0; cyc1(); cyc1(); vsync_x = 1;
        wait_hs(9, "vs2_hs");
        chk("vs2_addr", addr_q[8], 32'h0100_0200);

        wait_idle("frame_end");
        chk("frame_hs", hs_cnt, NB);
        chk("frame_wr", wr_cnt, NB * 16);
        chk("frame_last_addr", addr_q[NB-1], 32'h0100_05C0);
        repeat (20) begin chk("after_frame_arvalid", arvalid, 0); cyc1(); end

        // display disabled at beat 5 of the third burst
        start_frame(29'h00AB_CD40);
        wait_hs(3, "dis_setup");
        wait_beats(5, "dis_beat5");
        dispon = 0;
        wait_idle("dis_idle");
        chk("dis_hs", hs_cnt, 3);
        chk("dis_wr", wr_cnt, 48);
        chk("dis_third_addr", addr_q[2], 32'h00AB_CDC0);
        vsync_x = 0; cyc1(); vsync_x = 1;
        repeat (20) begin chk("dis_arvalid", arvalid, 0); cyc1(); end
        chk("dis_no_more_hs", hs_cnt, 3);

        // reset while data is streaming
        start_frame(29'h0020_0000);
        wait_hs(2, "rst_setup");
        wait_beats(7, "rst_beat7");
        arst = 1;
        cyc1();
        chk("rst_mid_rready", rready, 0);
        chk("rst_mid_arvalid", arvalid, 0);
        chk("rst_mid_buf_wr", buf_wr, 0);
        arst = 0;
        repeat (10) begin chk("rst_idle_arvalid", arvalid, 0); cyc1(); end

        start_frame(29'h0030_0000);
        wait_hs(2, "restart_hs");
        chk("restart_addr0", addr_q[0], 32'h0030_0000);
        chk("restart_addr1", addr_q[1], 32'h0030_0040);
        repeat (5) cyc1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
